// File: rtl/pixel_writer.sv
// Depth-shades closest-hit results into RGB565 and streams them into a linear framebuffer
// over an Avalon-MM write master, with a 2-entry FIFO absorbing memory stalls.
module pixel_writer #(
   parameter int unsigned FB_WIDTH  = 320,
   parameter int unsigned FB_HEIGHT = 240,
   parameter logic [15:0] BG_COLOR  = 16'h0000,
   parameter int unsigned T_SHIFT   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ivalid,
   input  logic        i_hit,
   input  logic [31:0] i_t,
   input  logic [31:0] baseaddr,
   output logic        o_ready,
   output logic [15:0] o_x,
   output logic [15:0] o_y,
   output logic        o_frame_done,
   output logic        avm_m0_write,
   output logic [31:0] avm_m0_address,
   output logic [15:0] avm_m0_writedata,
   output logic [1:0]  avm_m0_byteenable,
   input  logic        avm_m0_waitrequest
);

   localparam logic [0:0]  StIdle  = 1'b0;
   localparam logic [0:0]  StWrite = 1'b1;
   localparam logic [15:0] XLast   = 16'(FB_WIDTH - 1);
   localparam logic [15:0] YLast   = 16'(FB_HEIGHT - 1);
   localparam logic [31:0] LinLast = 32'(FB_WIDTH * FB_HEIGHT - 1);

   logic [0:0]  state_q, state_d;
   logic [15:0] mem_q [2];
   logic [15:0] mem_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] lin_q, lin_d;
   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic        frame_done_q, frame_done_d;

   logic signed [31:0] t_sh;
   logic [4:0]  inten;
   logic [15:0] colour;
   logic        push;
   logic        wr_done;

   assign t_sh = $signed(i_t) >>> T_SHIFT;

   always_comb begin
      inten  = (t_sh > 32'sd31) ? 5'd0 : ~t_sh[4:0];
      colour = {inten, inten, inten[4], inten};
      if (!i_hit || i_t[31]) begin
         colour = BG_COLOR;
      end
   end

   assign o_ready = !reset && (count_q != 2'd2);
   assign push    = ivalid && o_ready;
   assign wr_done = !reset && (state_q == StWrite) && !avm_m0_waitrequest;

   always_comb begin
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      if (push) begin
         mem_d[wr_ptr_q] = colour;
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ wr_done;
      count_d  = count_q + 2'(push) - 2'(wr_done);

      lin_d = lin_q;
      x_d   = x_q;
      y_d   = y_q;
      if (wr_done) begin
         if (x_q == XLast) begin
            x_d = 16'd0;
            if (y_q == YLast) begin
               y_d   = 16'd0;
               lin_d = 32'd0;
            end else begin
               y_d   = y_q + 16'd1;
               lin_d = lin_q + 32'd1;
            end
         end else begin
            x_d   = x_q + 16'd1;
            lin_d = lin_q + 32'd1;
         end
      end
      frame_done_d = wr_done && (lin_q == LinLast);

      // A push landing on the completion edge keeps the bus busy back-to-back.
      state_d = state_q;
      case (state_q)
         StIdle:  if (count_d != 2'd0) state_d = StWrite;
         StWrite: if (count_d == 2'd0) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         mem_q[0]     <= 16'd0;
         mem_q[1]     <= 16'd0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         lin_q        <= 32'd0;
         x_q          <= 16'd0;
         y_q          <= 16'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_q[0]     <= mem_d[0];
         mem_q[1]     <= mem_d[1];
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         lin_q        <= lin_d;
         x_q          <= x_d;
         y_q          <= y_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Outputs are forced low whenever reset is asserted, even before state clears.
   assign avm_m0_write      = !reset && (state_q == StWrite);
   assign avm_m0_address    = avm_m0_write ? baseaddr + {lin_q[30:0], 1'b0} : 32'd0;
   assign avm_m0_writedata  = avm_m0_write ? mem_q[rd_ptr_q] : 16'd0;
   assign avm_m0_byteenable = {2{avm_m0_write}};
   assign o_x               = reset ? 16'd0 : x_q;
   assign o_y               = reset ? 16'd0 : y_q;
   assign o_frame_done      = !reset && frame_done_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: a queue-based pixel model checked every cycle,
// plus directed scenarios with hand-computed addresses and colours.
module tb_pixel_writer;

   localparam int          W    = 4;
   localparam int          H    = 2;
   localparam logic [31:0] BASE = 32'h1000;
   localparam logic [15:0] BG   = 16'h1234;

   logic        clk = 1'b0;
   logic        reset;
   logic        ivalid;
   logic        i_hit;
   logic [31:0] i_t;
   logic [31:0] baseaddr;
   logic        o_ready;
   logic [15:0] o_x;
   logic [15:0] o_y;
   logic        o_frame_done;
   logic        avm_m0_write;
   logic [31:0] avm_m0_address;
   logic [15:0] avm_m0_writedata;
   logic [1:0]  avm_m0_byteenable;
   logic        avm_m0_waitrequest;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pixel_writer #(
      .FB_WIDTH (W),
      .FB_HEIGHT(H),
      .BG_COLOR (BG),
      .T_SHIFT  (16)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .ivalid            (ivalid),
      .i_hit             (i_hit),
      .i_t               (i_t),
      .baseaddr          (baseaddr),
      .o_ready           (o_ready),
      .o_x               (o_x),
      .o_y               (o_y),
      .o_frame_done      (o_frame_done),
      .avm_m0_write      (avm_m0_write),
      .avm_m0_address    (avm_m0_address),
      .avm_m0_writedata  (avm_m0_writedata),
      .avm_m0_byteenable (avm_m0_byteenable),
      .avm_m0_waitrequest(avm_m0_waitrequest)
   );

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  log_q[$];
   int   acc_idx  = 0;
   int   comp_idx = 0;
   logic fd_exp   = 1'b0;
   int   fd_count = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Intensity falls off one step per whole unit of distance; misses take the background.
   function automatic logic [15:0] model_colour(input logic hit, input int t);
      int d;
      int i;
      if (!hit || t < 0) return BG;
      d = t / 65536;
      if (d > 31) d = 31;
      i = 31 - d;
      return 16'(i * 2048 + (i * 2 + i / 16) * 32 + i);
   endfunction

   always @(negedge clk) begin
      int   sz;
      logic push;
      logic comp;
      if (reset) begin
         chk("rst_ready", o_ready, 0);
         chk("rst_write", avm_m0_write, 0);
         chk("rst_addr", avm_m0_address, 0);
         chk("rst_data", avm_m0_writedata, 0);
         chk("rst_be", avm_m0_byteenable, 0);
         chk("rst_xy", {o_x, o_y}, 0);
         chk("rst_fd", o_frame_done, 0);
         exp_q.delete();
         acc_idx  = 0;
         comp_idx = 0;
         fd_exp   = 1'b0;
      end else begin
         sz = exp_q.size();
         chk("ready", o_ready, sz < 2);
         chk("write", avm_m0_write, sz > 0);
         chk("byteenable", avm_m0_byteenable, (sz > 0) ? 2'b11 : 2'b00);
         if (sz > 0 && avm_m0_write) begin
            chk("address", avm_m0_address, exp_q[0].addr);
            chk("writedata", avm_m0_writedata, exp_q[0].data);
         end
         chk("o_x", o_x, comp_idx % W);
         chk("o_y", o_y, comp_idx / W);
         chk("frame_done", o_frame_done, fd_exp);
         if (o_frame_done) fd_count++;

         push   = ivalid && (sz < 2);
         comp   = (sz > 0) && !avm_m0_waitrequest;
         fd_exp = 1'b0;
         if (comp) begin
            log_q.push_back('{avm_m0_address, avm_m0_writedata});
            void'(exp_q.pop_front());
            fd_exp   = (comp_idx == W * H - 1);
            comp_idx = (comp_idx + 1) % (W * H);
         end
         if (push) begin
            exp_q.push_back('{32'(BASE + 2 * acc_idx), model_colour(i_hit, i_t)});
            acc_idx = (acc_idx + 1) % (W * H);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic hit, input logic [31:0] t);
      int   n   = 0;
      logic acc = 1'b0;
      ivalid = 1'b1;
      i_hit  = hit;
      i_t    = t;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         n++;
      end
      #1 ivalid = 1'b0;
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_log(input int n);
      int k = 0;
      while (log_q.size() < n && k < 100) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("drain_count", log_q.size() >= n, 1);
   endtask

   task automatic chk_log(input int idx, input logic [31:0] addr, input logic [15:0] data);
      if (log_q.size() > idx) begin
         chk("log_addr", log_q[idx].addr, addr);
         chk("log_data", log_q[idx].data, data);
      end else begin
         chk("log_missing", idx, -1);
      end
   endtask

   initial begin
      reset              = 1'b1;
      ivalid             = 1'b0;
      i_hit              = 1'b0;
      i_t                = 32'd0;
      baseaddr           = BASE;
      avm_m0_waitrequest = 1'b0;

      chk("model_pin_1", model_colour(1'b1, 65536), 16'hF7BE);
      chk("model_pin_2", model_colour(1'b1, 23831), 16'hFFFF);
      chk("model_pin_3", model_colour(1'b1, 40 << 16), 16'h0000);
      chk("model_pin_4", model_colour(1'b1, -65536), BG);

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", o_ready, 1);
      chk("xy_after_reset", {o_x, o_y}, 0);
      @(posedge clk);
      #1;

      send(1'b1, 32'd65536);
      send(1'b1, 32'd23831);
      send(1'b1, 32'(31 << 16));
      send(1'b1, 32'(40 << 16));
      send(1'b0, 32'd0);
      wait_log(5);
      chk_log(0, 32'h1000, 16'hF7BE);
      chk_log(1, 32'h1002, 16'hFFFF);
      chk_log(2, 32'h1004, 16'h0000);
      chk_log(3, 32'h1006, 16'h0000);
      chk_log(4, 32'h1008, BG);
      @(negedge clk);
      chk("xy_after_5", {o_x, o_y}, {16'd1, 16'd1});
      @(posedge clk);
      #1;

      send(1'b1, 32'hFFFF_0000);
      wait_log(6);
      chk_log(5, 32'h100A, BG);

      avm_m0_waitrequest = 1'b1;
      send(1'b1, 32'(2 << 16));
      send(1'b1, 32'(3 << 16));
      @(negedge clk);
      chk("ready_full", o_ready, 0);
      @(posedge clk);
      #1;
      fork
         begin
            repeat (4) @(posedge clk);
            #1 avm_m0_waitrequest = 1'b0;
         end
      join_none
      send(1'b1, 32'(5 << 16));
      wait_log(9);
      chk_log(6, 32'h100C, 16'hEF7D);
      chk_log(7, 32'h100E, 16'hE73C);
      chk_log(8, 32'h1000, 16'hD6BA);
      chk("frame_done_pulses", fd_count, 1);

      avm_m0_waitrequest = 1'b1;
      send(1'b1, 32'd65536);
      @(negedge clk);
      chk("write_before_reset", avm_m0_write, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      avm_m0_waitrequest = 1'b0;
      @(negedge clk);
      chk("write_after_reset", avm_m0_write, 0);
      chk("xy_after_midreset", {o_x, o_y}, 0);
      @(posedge clk);
      #1;
      send(1'b1, 32'd23831);
      wait_log(10);
      chk_log(9, 32'h1000, 16'hFFFF);
      chk("dropped_write", log_q.size(), 10);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
